network_pkt_read_arbiter: RTL and testbench

Shares the single read port of the packet buffer RAM between the two network transmit ports. Each port issues word-read requests (address, read strobe) and receives an ack pulse, then the data word with a write strobe. The block arbitrates one read per cycle round-robin and tracks in-flight reads through the fixed RAM latency so that each returned word is steered to the port that issued it. It sits between the network output process and the packet buffer.

---
 rtl/network_pkt_read_arbiter.sv | 89 ++++++++
 tb/tb_network_pkt_read_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/network_pkt_read_arbiter.sv
// Shares the packet-buffer RAM read port between two transmit ports: round-robin arbitration plus
// tag tracking through the fixed RAM latency. Define NETWORK_PKT_READ_P0_PRI_EN for strict port0 priority.
module network_pkt_read_arbiter #(
    parameter int RAM_LATENCY = 2  // legal 1..4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [15:0]  iv_pkt_raddr_p0,
    input  logic         i_pkt_rd_p0,
    output logic         o_pkt_raddr_ack_p0,
    output logic [133:0] ov_pkt_data_p0,
    output logic         o_pkt_data_wr_p0,
    input  logic [15:0]  iv_pkt_raddr_p1,
    input  logic         i_pkt_rd_p1,
    output logic         o_pkt_raddr_ack_p1,
    output logic [133:0] ov_pkt_data_p1,
    output logic         o_pkt_data_wr_p1,
    output logic [15:0]  ov_ram_raddr,
    output logic         o_ram_rd,
    input  logic [133:0] iv_ram_rdata
);

    localparam int STAGES = RAM_LATENCY;

    logic [1:0]      elig;
    logic            gnt_vld;
    logic            gnt_port;
    logic [1:0]      ack_q;
    logic [1:0]      wr_q;
    logic [15:0]     raddr_q;
    logic [133:0]    data_q;
    // Stage 0 is the issue cycle (drives o_ram_rd); stage STAGES lines up with returning RAM data.
    logic [STAGES:0] vld_pipe;
    logic [STAGES:0] port_pipe;

    // A port being acked this cycle still shows its old address, so it sits out one cycle.
    assign elig    = {i_pkt_rd_p1 & ~ack_q[1], i_pkt_rd_p0 & ~ack_q[0]};
    assign gnt_vld = |elig;

`ifdef NETWORK_PKT_READ_P0_PRI_EN
    assign gnt_port = ~elig[0];
`else
    logic last_grant;

    assign gnt_port = (&elig) ? ~last_grant : elig[1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant <= 1'b1;
        end else if (gnt_vld) begin
            last_grant <= gnt_port;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_q     <= '0;
            wr_q      <= '0;
            raddr_q   <= '0;
            data_q    <= '0;
            vld_pipe  <= '0;
            port_pipe <= '0;
        end else begin
            ack_q[0] <= gnt_vld & ~gnt_port;
            ack_q[1] <= gnt_vld & gnt_port;
            if (gnt_vld) begin
                raddr_q <= gnt_port ? iv_pkt_raddr_p1 : iv_pkt_raddr_p0;
            end
            vld_pipe  <= {vld_pipe[STAGES-1:0], gnt_vld};
            port_pipe <= {port_pipe[STAGES-1:0], gnt_port};
            wr_q[0]   <= vld_pipe[STAGES] & ~port_pipe[STAGES];
            wr_q[1]   <= vld_pipe[STAGES] & port_pipe[STAGES];
            if (vld_pipe[STAGES]) begin
                data_q <= iv_ram_rdata;
            end
        end
    end

    assign o_ram_rd           = vld_pipe[0];
    assign ov_ram_raddr       = raddr_q;
    assign o_pkt_raddr_ack_p0 = ack_q[0];
    assign o_pkt_raddr_ack_p1 = ack_q[1];
    assign o_pkt_data_wr_p0   = wr_q[0];
    assign o_pkt_data_wr_p1   = wr_q[1];
    assign ov_pkt_data_p0     = data_q;
    assign ov_pkt_data_p1     = data_q;

endmodule

// File: tb/tb_network_pkt_read_arbiter.sv
// Directed bench: three arbiters (RAM latency 2, 1, 4) share one request stimulus, each with its own RAM model.
module tb_network_pkt_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd0, rd1;
    logic [15:0] a0, a1;

    logic         ack0 [3];
    logic         ack1 [3];
    logic         wr0 [3];
    logic         wr1 [3];
    logic [133:0] data0 [3];
    logic [133:0] data1 [3];
    logic [15:0]  raddr [3];
    logic         ram_rd [3];
    logic [133:0] rdata [3];

    int lat [3] = '{2, 1, 4};
    int n_cmp = 0;
    int n_err = 0;

    // expected grant table, indexed by the step at which the grant becomes visible
    logic        gv [32];
    logic        gp [32];
    logic [15:0] ga [32];

    always #5 clk = ~clk;

    function automatic logic [133:0] f(input logic [15:0] a);
        return {2'b01, a, 100'h0, a ^ 16'hABCD};
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_dut
        localparam int L = (i == 0) ? 2 : (i == 1) ? 1 : 4;
        logic [133:0] pipe [1:4];

        network_pkt_read_arbiter #(.RAM_LATENCY(L)) dut (
            .i_clk(clk), .i_rst_n(rst_n),
            .iv_pkt_raddr_p0(a0), .i_pkt_rd_p0(rd0), .o_pkt_raddr_ack_p0(ack0[i]),
            .ov_pkt_data_p0(data0[i]), .o_pkt_data_wr_p0(wr0[i]),
            .iv_pkt_raddr_p1(a1), .i_pkt_rd_p1(rd1), .o_pkt_raddr_ack_p1(ack1[i]),
            .ov_pkt_data_p1(data1[i]), .o_pkt_data_wr_p1(wr1[i]),
            .ov_ram_raddr(raddr[i]), .o_ram_rd(ram_rd[i]), .iv_ram_rdata(rdata[i])
        );

        always @(posedge clk) begin
            pipe[1] <= f(raddr[i]);
            for (int k = 2; k <= 4; k++) pipe[k] <= pipe[k-1];
        end
        assign rdata[i] = pipe[L];
    end

    task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tab();
        for (int g = 0; g < 32; g++) begin
            gv[g] = 1'b0;
            gp[g] = 1'b0;
            ga[g] = 16'h0;
        end
    endtask

    // data return check for all three latencies at step s
    task automatic chk_ret(input int s);
        for (int i = 0; i < 3; i++) begin
            int   g;
            logic ev, ep;
            g  = s - lat[i] - 1;
            ev = (g >= 1 && g < 32) ? gv[g] : 1'b0;
            ep = (g >= 1 && g < 32) ? gp[g] : 1'b0;
            chk($sformatf("wr0_L%0d_s%0d", lat[i], s), {133'h0, wr0[i]}, {133'h0, ev & ~ep});
            chk($sformatf("wr1_L%0d_s%0d", lat[i], s), {133'h0, wr1[i]}, {133'h0, ev & ep});
            if (ev) begin
                chk($sformatf("data0_L%0d_s%0d", lat[i], s), data0[i], f(ga[g]));
                chk($sformatf("data1_L%0d_s%0d", lat[i], s), data1[i], f(ga[g]));
            end
        end
    endtask

    task automatic chk_idle_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_ramrd_L%0d", tag, lat[i]), {133'h0, ram_rd[i]}, '0);
            chk($sformatf("%s_raddr_L%0d", tag, lat[i]), {118'h0, raddr[i]}, '0);
            chk($sformatf("%s_ack0_L%0d", tag, lat[i]), {133'h0, ack0[i]}, '0);
            chk($sformatf("%s_ack1_L%0d", tag, lat[i]), {133'h0, ack1[i]}, '0);
            chk($sformatf("%s_wr0_L%0d", tag, lat[i]), {133'h0, wr0[i]}, '0);
            chk($sformatf("%s_wr1_L%0d", tag, lat[i]), {133'h0, wr1[i]}, '0);
            chk($sformatf("%s_data_L%0d", tag, lat[i]), data0[i], '0);
        end
    endtask

    initial begin
        int nack;
        logic prev_rd;

        rst_n = 1'b0; rd0 = 1'b0; rd1 = 1'b0; a0 = '0; a1 = '0;
        step(); step();
        chk_idle_all("reset");
        rst_n = 1'b1;
        step();

        // single port0 read of 0x0010
        clear_tab();
        gv[1] = 1'b1; gp[1] = 1'b0; ga[1] = 16'h0010;
        rd0 = 1'b1; a0 = 16'h0010;
        for (int s = 1; s <= 7; s++) begin
            step();
            if (s == 1) begin
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("single_ack0_L%0d", lat[i]), {133'h0, ack0[i]}, 134'h1);
                    chk($sformatf("single_ack1_L%0d", lat[i]), {133'h0, ack1[i]}, 134'h0);
                    chk($sformatf("single_ramrd_L%0d", lat[i]), {133'h0, ram_rd[i]}, 134'h1);
                    chk($sformatf("single_raddr_L%0d", lat[i]), {118'h0, raddr[i]}, 134'h10);
                end
                rd0 = 1'b0;
            end
            if (s == 2) chk("single_ramrd_off", {133'h0, ram_rd[0]}, 134'h0);
            chk_ret(s);
        end
        chk("hold_data1", data1[0], f(16'h0010));
        chk("hold_raddr", {118'h0, raddr[0]}, 134'h10);

        // ack mask: port0 holds one address for 4 cycles
        clear_tab();
        gv[1] = 1'b1; ga[1] = 16'h0055;
        gv[3] = 1'b1; ga[3] = 16'h0055;
        rd0 = 1'b1; a0 = 16'h0055;
        nack = 0; prev_rd = 1'b0;
        for (int s = 1; s <= 8; s++) begin
            step();
            chk($sformatf("mask_ack0_s%0d", s), {133'h0, ack0[0]}, {133'h0, gv[s]});
            chk($sformatf("mask_b2b_s%0d", s), {133'h0, ram_rd[0] & prev_rd}, 134'h0);
            nack += int'(ack0[0]);
            prev_rd = ram_rd[0];
            if (s == 4) rd0 = 1'b0;
            chk_ret(s);
        end
        chk("mask_ack_count", 134'(nack), 134'd2);

        // two grants, then reset while their data is in flight
        rd0 = 1'b1; rd1 = 1'b1; a0 = 16'h0030; a1 = 16'h0130;
        step();
        chk("mf_ramrd_1", {133'h0, ram_rd[0]}, 134'h1);
`ifdef NETWORK_PKT_READ_P0_PRI_EN
        chk("mf_raddr_1", {118'h0, raddr[0]}, 134'h30);
`else
        chk("mf_raddr_1", {118'h0, raddr[0]}, 134'h130);
`endif
        step();
        chk("mf_ramrd_2", {133'h0, ram_rd[0]}, 134'h1);
`ifdef NETWORK_PKT_READ_P0_PRI_EN
        chk("mf_raddr_2", {118'h0, raddr[0]}, 134'h130);
`else
        chk("mf_raddr_2", {118'h0, raddr[0]}, 134'h30);
`endif
        #2;
        rst_n = 1'b0; rd0 = 1'b0; rd1 = 1'b0;
        #1;
        chk_idle_all("midrst");
        step();
        rst_n = 1'b1;
        for (int s = 1; s <= 8; s++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("postrst_wr0_L%0d_s%0d", lat[i], s), {133'h0, wr0[i]}, 134'h0);
                chk($sformatf("postrst_wr1_L%0d_s%0d", lat[i], s), {133'h0, wr1[i]}, 134'h0);
            end
        end

        // contention: alternating grants, then a fresh contention after last grant went to port0
        clear_tab();
        for (int g = 1; g <= 7; g++) begin
            gv[g] = 1'b1;
            gp[g] = (g % 2 == 0);
            ga[g] = (g % 2 == 1) ? 16'((g - 1) / 2) : 16'(16'h0100 + g / 2 - 1);
        end
        gv[9] = 1'b1;
`ifdef NETWORK_PKT_READ_P0_PRI_EN
        gp[9] = 1'b0; ga[9] = 16'h0020;
`else
        gp[9] = 1'b1; ga[9] = 16'h0120;
`endif
        rd0 = 1'b1; rd1 = 1'b1; a0 = 16'h0000; a1 = 16'h0100;
        for (int s = 1; s <= 16; s++) begin
            step();
            if (s <= 9) begin
                chk($sformatf("cont_ramrd_s%0d", s), {133'h0, ram_rd[0]}, {133'h0, gv[s]});
                chk($sformatf("cont_ack0_s%0d", s), {133'h0, ack0[0]}, {133'h0, gv[s] & ~gp[s]});
                chk($sformatf("cont_ack1_s%0d", s), {133'h0, ack1[0]}, {133'h0, gv[s] & gp[s]});
                if (gv[s]) begin
                    for (int i = 0; i < 3; i++)
                        chk($sformatf("cont_raddr_L%0d_s%0d", lat[i], s), {118'h0, raddr[i]}, {118'h0, ga[s]});
                end
            end
            chk_ret(s);
            if (s < 7) begin
                if (ack0[0]) a0 = a0 + 16'h1;
                if (ack1[0]) a1 = a1 + 16'h1;
            end else if (s == 7) begin
                rd0 = 1'b0; rd1 = 1'b0;
            end else if (s == 8) begin
                rd0 = 1'b1; rd1 = 1'b1; a0 = 16'h0020; a1 = 16'h0120;
            end else begin
                rd0 = 1'b0; rd1 = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
